// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter for a fixed-latency flash read port.
// Each grant runs a burst of ISSUE/WAIT pairs, one word per pair, ending in a one-cycle FIN.
module flash_arbiter #(
  parameter int READ_LAT = 12
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  input  logic [15:0] flash_data,
  output logic        flash_ready,
  output logic [15:0] flash_addr,
  output logic [15:0] rdata,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        done0,
  output logic        done1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t      state, nxt;
  logic        owner, last;
  logic [7:0]  cnt, remaining;
  logic [15:0] cur_addr;
  logic        pick_valid, pick, wait_done;
  logic [7:0]  pick_len;

  // Contention goes to whoever was not granted last; a lone request simply wins.
  always_comb begin
    pick_valid = req0 | req1;
    pick       = (req0 & req1) ? ~last : req1;
    pick_len   = pick ? len1 : len0;
    wait_done  = (state == WAIT) && (cnt == 8'(READ_LAT - 1));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (pick_valid) nxt = (pick_len == 8'd0) ? FIN : ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (wait_done) nxt = (remaining == 8'd1) ? FIN : ISSUE;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      remaining <= '0;
      cur_addr  <= '0;
      rdata     <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= wait_done & ~owner;
      rvalid1 <= wait_done & owner;
      case (state)
        IDLE: if (pick_valid) begin
          owner     <= pick;
          last      <= pick;
          cur_addr  <= pick ? addr1 : addr0;
          remaining <= pick_len;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (wait_done) begin
            rdata     <= flash_data;
            remaining <= remaining - 8'd1;
            cur_addr  <= cur_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flash_ready = (state == ISSUE);
    flash_addr  = cur_addr;
    busy        = (state != IDLE);
    gnt0        = busy & ~owner;
    gnt1        = busy & owner;
    done0       = (state == FIN) & ~owner;
    done1       = (state == FIN) & owner;
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter: stimulus queues expected per-cycle events,
// a negedge monitor pops and compares whenever the DUT strobes or pulses.
module tb_flash_arbiter;

  logic        clk = 1'b0, n_rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  len0 = '0, len1 = '0;
  logic        fd_fixed = 1'b0;
  logic [15:0] flash_data;
  logic        flash_ready, rvalid0, rvalid1, done0, done1, gnt0, gnt1, busy;
  logic [15:0] flash_addr, rdata;

  int cyc = 0, n_chk = 0, n_pass = 0;

  // sig = {flash_ready, rvalid0, rvalid1, done0, done1}; gnt = {gnt0, gnt1}
  typedef struct {
    int          cyc;
    logic [4:0]  sig;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  gnt;
  } ev_t;
  ev_t q[$];

  flash_arbiter #(.READ_LAT(12)) dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .flash_data(flash_data), .flash_ready(flash_ready), .flash_addr(flash_addr),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy)
  );

  // Flash model: either a fixed word or an address-derived pattern.
  assign flash_data = fd_fixed ? 16'hBEEF : (flash_addr ^ 16'h5A5A);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(int c, logic [4:0] s, logic [15:0] a, logic [15:0] d, logic [1:0] g);
    ev_t e;
    e.cyc = c; e.sig = s; e.addr = a; e.data = d; e.gnt = g;
    q.push_back(e);
  endfunction

  task automatic tick_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ctrl"}, 64'({flash_ready, busy, gnt0, gnt1, rvalid0, rvalid1, done0, done1}), 64'd0);
    chk({tag, "_faddr"}, 64'(flash_addr), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    logic [4:0]  sig;
    logic [55:0] obs, exp;
    chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_event", 64'(cyc), 64'(q[0].cyc));
      void'(q.pop_front());
    end
    sig = {flash_ready, rvalid0, rvalid1, done0, done1};
    if (|sig) begin
      if (q.size() == 0) chk("unexpected_event", 64'({cyc[15:0], sig}), 64'd0);
      else begin
        e   = q.pop_front();
        obs = {cyc[15:0], sig, flash_ready ? flash_addr : 16'h0,
               (rvalid0 | rvalid1) ? rdata : 16'h0, gnt0, gnt1, busy};
        exp = {e.cyc[15:0], e.sig, e.addr, e.data, e.gnt, 1'b1};
        chk("event", 64'(obs), 64'(exp));
      end
    end
  end

  initial begin
    int g;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Single word, fixed flash data
    g = cyc; fd_fixed = 1'b1;
    req0 = 1'b1; addr0 = 16'h0100; len0 = 8'd1;
    push(g + 1,  5'b10000, 16'h0100, 16'h0000, 2'b10);
    push(g + 14, 5'b01010, 16'h0000, 16'hBEEF, 2'b10);
    tick_to(g + 14); req0 = 1'b0;
    tick_to(g + 16); fd_fixed = 1'b0;

    // Two-word burst wrapping 0xFFFF -> 0x0000
    g = cyc;
    req1 = 1'b1; addr1 = 16'hFFFF; len1 = 8'd2;
    push(g + 1,  5'b10000, 16'hFFFF, 16'h0000, 2'b01);
    push(g + 14, 5'b10100, 16'h0000, 16'hA5A5, 2'b01);
    push(g + 27, 5'b00101, 16'h0000, 16'h5A5A, 2'b01);
    tick_to(g + 27); req1 = 1'b0;
    tick_to(g + 29);

    // Contention straight out of reset
    n_rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset_outs("reset2");
    g = cyc; n_rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0020; len0 = 8'd1; len1 = 8'd1;
    push(g + 1,  5'b10000, 16'h0010, 16'h0000, 2'b10);
    push(g + 14, 5'b01010, 16'h0000, 16'h5A4A, 2'b10);
    push(g + 16, 5'b10000, 16'h0020, 16'h0000, 2'b01);
    push(g + 29, 5'b00101, 16'h0000, 16'h5A7A, 2'b01);
    push(g + 31, 5'b10000, 16'h0010, 16'h0000, 2'b10);
    push(g + 44, 5'b01010, 16'h0000, 16'h5A4A, 2'b10);
    tick_to(g + 29); req1 = 1'b0;
    tick_to(g + 44); req0 = 1'b0;
    tick_to(g + 46);

    // Zero length
    g = cyc;
    req0 = 1'b1; addr0 = 16'h0700; len0 = 8'd0;
    push(g + 1, 5'b00010, 16'h0000, 16'h0000, 2'b10);
    tick_to(g + 1); req0 = 1'b0;
    tick_to(g + 2);
    chk("zero_len_idle", 64'({busy, gnt0, gnt1}), 64'd0);
    tick_to(g + 4);

    // Reset during the WAIT of word 2, then a fresh request from requester 1
    g = cyc;
    req0 = 1'b1; addr0 = 16'h0200; len0 = 8'd4;
    push(g + 1,  5'b10000, 16'h0200, 16'h0000, 2'b10);
    push(g + 14, 5'b11000, 16'h0201, 16'h585A, 2'b10);
    tick_to(g + 18);
    n_rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_reset");
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    g = cyc;
    req1 = 1'b1; addr1 = 16'h0300; len1 = 8'd1;
    push(g + 1,  5'b10000, 16'h0300, 16'h0000, 2'b01);
    push(g + 14, 5'b00101, 16'h0000, 16'h595A, 2'b01);
    tick_to(g + 14); req1 = 1'b0;
    tick_to(g + 16);

    // req0 dropped after grant; req1 waits the whole burst out
    g = cyc;
    req0 = 1'b1; addr0 = 16'h0400; len0 = 8'd3;
    push(g + 1,  5'b10000, 16'h0400, 16'h0000, 2'b10);
    push(g + 14, 5'b11000, 16'h0401, 16'h5E5A, 2'b10);
    push(g + 27, 5'b11000, 16'h0402, 16'h5E5B, 2'b10);
    push(g + 40, 5'b01010, 16'h0000, 16'h5E58, 2'b10);
    push(g + 42, 5'b10000, 16'h0500, 16'h0000, 2'b01);
    push(g + 55, 5'b00101, 16'h0000, 16'h5F5A, 2'b01);
    tick_to(g + 2);
    req0 = 1'b0; req1 = 1'b1; addr1 = 16'h0500; len1 = 8'd1;
    tick_to(g + 20);
    chk("rdata_hold", 64'(rdata), 64'h5E5A);
    tick_to(g + 55); req1 = 1'b0;
    tick_to(g + 58);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
